ctr_stream_xcrypt: RTL

//  Multi-channel CTR-mode encrypt/decrypt engine (XOR with keystream, same path both directions).

---
 rtl/ctr_stream_xcrypt.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ctr_stream_xcrypt.sv
// ctr_stream_xcrypt: multi-channel CTR-mode XOR engine driving an external in-order block-cipher core.
// Define CTR_WRAP_ERR_EN to flag per-channel counter wrap in ctr_wrap_err.
module ctr_stream_xcrypt #(
    parameter int DATA_WIDTH = 256,
    parameter int CTR_WIDTH  = 32,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  key_ready,
    input  logic                  key_update,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [CH_W-1:0]       s_ch,
    input  logic                  s_first,
    input  logic                  s_last,
    input  logic [DATA_WIDTH-1:0] s_iv,
    output logic                  ks_req_valid,
    output logic [DATA_WIDTH-1:0] ks_req_block,
    input  logic                  ks_rsp_valid,
    input  logic [DATA_WIDTH-1:0] ks_rsp_block,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CH_W-1:0]       m_ch,
    output logic                  m_last,
    output logic [NUM_CH-1:0]     ctr_wrap_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {WAIT_KEY, RUN, DRAIN} state_e;
    state_e state_q, state_d;
    logic run;
    logic [AW:0] in_flight_q;
    logic accept, m_take, load;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= WAIT_KEY;
        else          state_q <= state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_KEY: if (key_ready && !key_update) state_d = RUN;
            RUN:      if (key_update || !key_ready) state_d = DRAIN;
            DRAIN:    if (!key_update && key_ready && in_flight_q == '0) state_d = RUN;
            default:  state_d = WAIT_KEY;
        endcase
    end

    always_comb run = (state_q == RUN);

    assign s_ready = run && (in_flight_q < FULL);
    assign accept  = s_valid && s_ready;
    assign m_take  = m_valid && m_ready;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) in_flight_q <= '0;
        else          in_flight_q <= in_flight_q + (AW+1)'(accept) - (AW+1)'(m_take);

    // Only the low CTR_WIDTH bits count; the nonce above them never takes a carry.
    logic [DATA_WIDTH-1:0] ctr_q [NUM_CH];
    logic [DATA_WIDTH-1:0] blk_d, ctr_d;
    assign blk_d = s_first ? s_iv : ctr_q[s_ch];
    assign ctr_d = {blk_d[DATA_WIDTH-1:CTR_WIDTH], blk_d[CTR_WIDTH-1:0] + CTR_WIDTH'(1)};

    logic                  ks_req_valid_q;
    logic [DATA_WIDTH-1:0] ks_req_block_q;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) ctr_q[i] <= '0;
            ks_req_valid_q <= 1'b0;
            ks_req_block_q <= '0;
        end else begin
            if (accept) ctr_q[s_ch] <= ctr_d;
            ks_req_valid_q <= accept;
            if (accept) ks_req_block_q <= blk_d;
        end

    assign ks_req_valid = ks_req_valid_q;
    assign ks_req_block = ks_req_block_q;

    logic [DATA_WIDTH-1:0] d_mem [DEPTH];
    logic [CH_W-1:0]       c_mem [DEPTH];
    logic                  l_mem [DEPTH];
    logic [DATA_WIDTH-1:0] k_mem [DEPTH];
    logic [AW:0] dw_q, dr_q, kw_q, kr_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            d_mem[dw_q[AW-1:0]] <= s_data;
            c_mem[dw_q[AW-1:0]] <= s_ch;
            l_mem[dw_q[AW-1:0]] <= s_last;
        end
        if (ks_rsp_valid) k_mem[kw_q[AW-1:0]] <= ks_rsp_block;
    end

    assign load = (dw_q != dr_q) && (kw_q != kr_q) && (!m_valid || m_ready);

    logic                  m_valid_q, m_last_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic [CH_W-1:0]       m_ch_q;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            dw_q      <= '0;
            dr_q      <= '0;
            kw_q      <= '0;
            kr_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
            m_last_q  <= 1'b0;
        end else begin
            if (accept) dw_q <= dw_q + 1'b1;
            if (ks_rsp_valid) kw_q <= kw_q + 1'b1;
            if (load) begin
                dr_q      <= dr_q + 1'b1;
                kr_q      <= kr_q + 1'b1;
                m_valid_q <= 1'b1;
                m_data_q  <= d_mem[dr_q[AW-1:0]] ^ k_mem[kr_q[AW-1:0]];
                m_ch_q    <= c_mem[dr_q[AW-1:0]];
                m_last_q  <= l_mem[dr_q[AW-1:0]];
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_ch    = m_ch_q;
    assign m_last  = m_last_q;

`ifdef CTR_WRAP_ERR_EN
    logic [NUM_CH-1:0] wrap_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)                                         wrap_q <= '0;
        else if (accept && s_first)                           wrap_q[s_ch] <= 1'b0;
        else if (accept && (&ctr_q[s_ch][CTR_WIDTH-1:0]))     wrap_q[s_ch] <= 1'b1;
    assign ctr_wrap_err = wrap_q;
`else
    assign ctr_wrap_err = '0;
`endif
endmodule
